wb_stage_regfile: RTL and testbench
===================================

Name: wb_stage_regfile

Overview:
- Write-back end of the RV32I 5-stage pipeline.
- Consumes the MEM/WB pipeline register outputs and selects the write-back value (ALU result, load data, or PC+4).
- Commits that value to the 32x32 integer register file and serves the two decode-stage read ports.
- Exports the write-back value and destination for EX-stage forwarding, and keeps a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath/register width.
- NREGS, 32, number of architectural registers. x0 is always hardwired to zero.

Ports:
- CLK  input  1  pipeline clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- PC_O  input  32  PC of the instruction in write-back
- Reg_Wr_En_O  input  1  register write enable from MEM/WB
- mem_wb_rd  input  5  destination register index
- result_O  input  XLEN  ALU result
- Src_to_Reg_O  input  2  write-back source select
- DMEM_O  input  XLEN  load data, already aligned and extended
- wb_valid  input  1  a real (non-bubble) instruction occupies write-back this cycle
- rs1_addr  input  5  decode read port 1 index
- rs2_addr  input  5  decode read port 2 index
- rs1_data  output  XLEN  read data, port 1
- rs2_data  output  XLEN  read data, port 2
- wb_data  output  XLEN  selected write-back value (forwarding source)
- wb_rd  output  5  equals mem_wb_rd
- wb_we  output  1  effective write enable (forwarding qualifier)
- instret  output  64  retired-instruction count

Behaviour:
- Clock and reset: single clock CLK. Reset rst_n is asynchronous, active-low. All storage (register file, instret) clears when rst_n is low.
- Source select (combinational, Src_to_Reg_O):
  - 2'b00: wb_data = result_O
  - 2'b01: wb_data = DMEM_O
  - 2'b10: wb_data = PC_O + 4 (mod 2^32)
  - 2'b11: wb_data = 0
- Effective write enable: wb_we = Reg_Wr_En_O & wb_valid & (mem_wb_rd != 0).
  - wb_rd passes mem_wb_rd through unchanged.
- Register write: on the rising edge of CLK with wb_we=1, regs[mem_wb_rd] <= wb_data.
  - Writes to x0 are discarded. x0 reads 0 always.
- Read ports: combinational, asynchronous.
  - rs1_data = regs[rs1_addr], or 0 if rs1_addr == 0. rs2_data likewise.
- Same-cycle write/read of the same register: behaviour depends on REGFILE_BYPASS_EN (see Optional Feature).
- instret:
  - Increments by 1 on each rising edge with wb_valid=1, whether or not the instruction writes a register.
  - Wraps from 2^64-1 to 0.
  - Reset value is 0.
- Reset values:
  - All regs: 0.
  - instret: 0.
  - Combinational outputs follow their inputs during reset, with the regfile reading 0.
  - wb_we is forced to 0 while rst_n is low.
- Reset mid-operation: an asserted reset aborts any pending write. No write occurs on a clock edge while rst_n is low. The first write is possible on the first rising edge after deassertion.
- Latency:
  - Write-back to register visible: next cycle (or the same cycle with bypass).
  - wb_data / wb_we: 0 cycles (combinational).
- Both read ports addressing the same register return identical data.

Optional Feature:
- REGFILE_BYPASS_EN.
- When defined: if wb_we=1 and rsN_addr == mem_wb_rd, rsN_data = wb_data in the same cycle (write-through read). This removes the WB-to-ID hazard without a forwarding mux in decode.
- When undefined: read ports return stored contents only. The new value is visible from the cycle after the write edge, and the hazard unit must stall or forward.

Test Plan:
- Reset: drive rst_n=0 mid-run after writing x5=0x1234 -> x5 reads 0, instret=0. Assert that no write occurs while rst_n is low.
- Source select: Reg_Wr_En_O=1, wb_valid=1, rd=3.
  - Src 00, result_O=0xDEADBEEF -> x3=0xDEADBEEF next cycle.
  - Src 01, DMEM_O=0x55 -> x3=0x55.
  - Src 10, PC_O=0x100 -> x3=0x104.
  - Src 11 -> x3=0.
- x0 protection: write 0xFFFFFFFF to rd=0 -> wb_we=0, rs1_addr=0 reads 0. A bubble (wb_valid=0, Reg_Wr_En_O=1, rd=7) leaves x7 unchanged.
- Same-cycle hazard: write x9=0xA5A5A5A5 while rs1_addr=rs2_addr=9.
  - With REGFILE_BYPASS_EN: both ports read 0xA5A5A5A5 in the same cycle.
  - Without it: both ports read the old value, then the new value the next cycle.
- instret:
  - 10 cycles with wb_valid=1, 3 of which are stores with Reg_Wr_En_O=0 -> instret=10.
  - Preload instret near 2^64-1 via force, then one more retire -> wraps to 0.
- PC+4 wrap: PC_O=0xFFFFFFFC, Src 10 -> wb_data=0x00000000.

Source files
------------

// File: rtl/wb_stage_regfile_if.sv
// rtl/wb_stage_regfile_if.sv - MEM/WB-to-regfile bus: write-back inputs, decode read ports, forwarding and instret outputs
interface wb_stage_regfile_if #(
    parameter int XLEN = 32
);
    logic [31:0]     PC_O;
    logic            Reg_Wr_En_O;
    logic [4:0]      mem_wb_rd;
    logic [XLEN-1:0] result_O;
    logic [1:0]      Src_to_Reg_O;
    logic [XLEN-1:0] DMEM_O;
    logic            wb_valid;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      wb_rd;
    logic            wb_we;
    logic [63:0]     instret;

    // Pipeline side: drives MEM/WB state and read addresses, consumes results
    modport master (
        output PC_O, Reg_Wr_En_O, mem_wb_rd, result_O, Src_to_Reg_O, DMEM_O,
               wb_valid, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_data, wb_rd, wb_we, instret
    );

    // Write-back stage / register file side
    modport slave (
        input  PC_O, Reg_Wr_En_O, mem_wb_rd, result_O, Src_to_Reg_O, DMEM_O,
               wb_valid, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_data, wb_rd, wb_we, instret
    );
endinterface

// File: rtl/wb_stage_regfile.sv
// rtl/wb_stage_regfile.sv - RV32I write-back stage with 32x32 regfile and instret; optional REGFILE_BYPASS_EN write-through reads
module wb_stage_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                CLK,
    input  logic                rst_n,
    wb_stage_regfile_if.slave   bus
);
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] sel_data;
    logic            eff_we;
    logic [63:0]     instret_q;

    // Write-back source mux; PC+4 wraps naturally at 2^32
    always_comb begin
        sel_data = '0;
        case (bus.Src_to_Reg_O)
            2'b00:   sel_data = bus.result_O;
            2'b01:   sel_data = bus.DMEM_O;
            2'b10:   sel_data = bus.PC_O + 32'd4;
            default: sel_data = '0;
        endcase
    end

    // Only real instructions targeting x1..x31 commit; reset suppresses commits
    always_comb begin
        eff_we = rst_n & bus.Reg_Wr_En_O & bus.wb_valid & (bus.mem_wb_rd != 5'd0);
    end

    assign bus.wb_data = sel_data;
    assign bus.wb_we   = eff_we;
    assign bus.wb_rd   = bus.mem_wb_rd;
    assign bus.instret = instret_q;

    // Register file storage; x0 is never written and reads are masked for it
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (eff_we) begin
            regs[bus.mem_wb_rd] <= sel_data;
        end
    end

    // Retired-instruction counter, counts every valid instruction including stores
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (bus.wb_valid) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    // Asynchronous read ports, optionally writing through the in-flight value
    always_comb begin
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        if (bus.rs1_addr != 5'd0) begin
            bus.rs1_data = regs[bus.rs1_addr];
        end
        if (bus.rs2_addr != 5'd0) begin
            bus.rs2_data = regs[bus.rs2_addr];
        end
`ifdef REGFILE_BYPASS_EN
        if (eff_we && (bus.rs1_addr == bus.mem_wb_rd)) begin
            bus.rs1_data = sel_data;
        end
        if (eff_we && (bus.rs2_addr == bus.mem_wb_rd)) begin
            bus.rs2_data = sel_data;
        end
`endif
    end
endmodule

// File: tb/tb_wb_stage_regfile.sv
// tb/tb_wb_stage_regfile.sv - directed self-checking bench for wb_stage_regfile
module tb_wb_stage_regfile;
    logic CLK;
    logic rst_n;
    int   vectors;
    int   miscompares;

    wb_stage_regfile_if #(.XLEN(32)) bus ();

    wb_stage_regfile #(.XLEN(32), .NREGS(32)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic valid, input logic [4:0] rd,
                         input logic [1:0] src, input logic [31:0] res);
        bus.Reg_Wr_En_O  = en;
        bus.wb_valid     = valid;
        bus.mem_wb_rd    = rd;
        bus.Src_to_Reg_O = src;
        bus.result_O     = res;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.PC_O    = 32'h0;
        bus.DMEM_O  = 32'h0;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        idle();
        tick();
        tick();

        check("reset_instret", bus.instret, 64'd0);
        bus.rs1_addr = 5'd5;
        #1;
        check("reset_x5", {32'h0, bus.rs1_data}, 64'h0);

        // Release reset, commit x5=0x1234
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h0000_1234);
        tick();
        idle();
        #1;
        check("x5_written", {32'h0, bus.rs1_data}, 64'h1234);
        check("instret_1", bus.instret, 64'd1);

        // Mid-run asynchronous reset clears storage immediately
        rst_n = 1'b0;
        #1;
        check("async_rst_x5", {32'h0, bus.rs1_data}, 64'h0);
        check("async_rst_instret", bus.instret, 64'd0);

        // Write attempt while in reset must be blocked
        drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h0000_0777);
        #1;
        check("rst_wb_we", {63'h0, bus.wb_we}, 64'd0);
        check("rst_wb_data_follows", {32'h0, bus.wb_data}, 64'h777);
        tick();
        check("rst_no_write", {32'h0, bus.rs1_data}, 64'h0);
        check("rst_no_count", bus.instret, 64'd0);
        idle();
        #1;
        rst_n = 1'b1;

        // 10 retires, iterations 2,5,8 are stores (no register write)
        for (int i = 0; i < 10; i++) begin
            drive(!(i == 2 || i == 5 || i == 8), 1'b1, 5'(10 + i), 2'b00, 32'(i + 1));
            tick();
        end
        idle();
        bus.rs1_addr = 5'd11;
        bus.rs2_addr = 5'd12;
        #1;
        check("instret_10", bus.instret, 64'd10);
        check("x11_written", {32'h0, bus.rs1_data}, 64'h2);
        check("x12_store_untouched", {32'h0, bus.rs2_data}, 64'h0);

        // Source select into x3
        bus.rs1_addr = 5'd3;
        drive(1'b1, 1'b1, 5'd3, 2'b00, 32'hDEAD_BEEF);
        #1;
        check("src00_wb_data", {32'h0, bus.wb_data}, 64'hDEAD_BEEF);
        check("wb_rd", {59'h0, bus.wb_rd}, 64'd3);
        check("wb_we_on", {63'h0, bus.wb_we}, 64'd1);
        tick();
        check("src00_x3", {32'h0, bus.rs1_data}, 64'hDEAD_BEEF);

        bus.DMEM_O = 32'h0000_0055;
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0);
        tick();
        check("src01_x3", {32'h0, bus.rs1_data}, 64'h55);

        bus.PC_O = 32'h0000_0100;
        drive(1'b1, 1'b1, 5'd3, 2'b10, 32'h0);
        tick();
        check("src10_x3", {32'h0, bus.rs1_data}, 64'h104);

        drive(1'b1, 1'b1, 5'd3, 2'b11, 32'hFFFF_FFFF);
        tick();
        check("src11_x3", {32'h0, bus.rs1_data}, 64'h0);

        // PC+4 wraps at 2^32
        bus.PC_O = 32'hFFFF_FFFC;
        drive(1'b0, 1'b0, 5'd0, 2'b10, 32'h0);
        #1;
        check("pc4_wrap", {32'h0, bus.wb_data}, 64'h0);

        // x0 protection
        bus.rs1_addr = 5'd0;
        drive(1'b1, 1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF);
        #1;
        check("x0_wb_we", {63'h0, bus.wb_we}, 64'd0);
        tick();
        check("x0_reads_zero", {32'h0, bus.rs1_data}, 64'h0);

        // Bubble must not overwrite x7
        bus.rs1_addr = 5'd7;
        drive(1'b1, 1'b1, 5'd7, 2'b00, 32'h0000_0077);
        tick();
        drive(1'b1, 1'b0, 5'd7, 2'b00, 32'h0000_0BAD);
        #1;
        check("bubble_wb_we", {63'h0, bus.wb_we}, 64'd0);
        tick();
        check("bubble_x7_kept", {32'h0, bus.rs1_data}, 64'h77);

        // Same-cycle write/read of x9
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd9;
        drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h1111_1111);
        tick();
        drive(1'b1, 1'b1, 5'd9, 2'b00, 32'hA5A5_A5A5);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_rs1_same", {32'h0, bus.rs1_data}, 64'hA5A5_A5A5);
        check("hazard_rs2_same", {32'h0, bus.rs2_data}, 64'hA5A5_A5A5);
`else
        check("hazard_rs1_old", {32'h0, bus.rs1_data}, 64'h1111_1111);
        check("hazard_rs2_old", {32'h0, bus.rs2_data}, 64'h1111_1111);
`endif
        tick();
        idle();
        #1;
        check("hazard_rs1_new", {32'h0, bus.rs1_data}, 64'hA5A5_A5A5);
        check("hazard_rs2_new", {32'h0, bus.rs2_data}, 64'hA5A5_A5A5);

        // 10 + 4 source + x0 + x7 write (bubble not counted) + 2 hazard writes
        check("instret_18", bus.instret, 64'd18);

        // instret wrap
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("instret_preload", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, 1'b1, 5'd0, 2'b00, 32'h0);
        tick();
        idle();
        #1;
        check("instret_wrap", bus.instret, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
